// File: rtl/piano_pkg.sv
// Shared types and constants for the piano voice datapath.
package piano_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ATTACK,
    DECAY,
    SUSTAIN,
    RELEASE
  } env_state_t;

  localparam int unsigned CLK_HZ_DEFAULT = 50_000_000;
  localparam int unsigned SAMPLE_W       = 8;

endpackage

// File: rtl/tone_voice_if.sv
// Note request in, audio out: the bundle between the key decoder and one voice.
interface tone_voice_if;
  import piano_pkg::*;

  logic [15:0]         sample_rate;
  logic [15:0]         arm_Rate;
  logic [SAMPLE_W-1:0] sample;
  logic                audio_pwm;
  logic                note_active;

  modport master (
    output sample_rate,
    output arm_Rate,
    input  sample,
    input  audio_pwm,
    input  note_active
  );

  modport slave (
    input  sample_rate,
    input  arm_Rate,
    output sample,
    output audio_pwm,
    output note_active
  );

endinterface

// File: rtl/pwm_dac.sv
// Free-running 8-bit PWM; a level of 255 gives 255/256 duty.
module pwm_dac
  import piano_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic [SAMPLE_W-1:0] level,
  output logic                pwm
);

  logic [SAMPLE_W-1:0] cnt_q;
  logic                pwm_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      pwm_q <= 1'b0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
      pwm_q <= (cnt_q < level);
    end
  end

  assign pwm = pwm_q;

endmodule

// File: rtl/tone_voice.sv
// Single square-wave voice with ADSR envelope, driving an 8-bit sample and a PWM pin.
module tone_voice
  import piano_pkg::*;
#(
  parameter int unsigned CLK_HZ      = CLK_HZ_DEFAULT,
  parameter int unsigned SUSTAIN_LVL = 192,
  parameter int unsigned ACC_W       = $clog2(CLK_HZ) + 1
) (
  input logic         clk,
  input logic         reset,
  tone_voice_if.slave voice
);

  localparam int unsigned AccW1 = ACC_W + 1;
  localparam logic [ACC_W:0] ClkHz = AccW1'(CLK_HZ);
  localparam logic [SAMPLE_W-1:0] SustainLvl = SAMPLE_W'(SUSTAIN_LVL);
  localparam logic [SAMPLE_W-1:0] AmpMax = '1;

  logic [15:0]         freq_q, rate_q;
  logic [15:0]         freq_hold_q, rate_hold_q;
  logic [ACC_W-1:0]    tacc_q, eacc_q;
  logic [ACC_W:0]      tone_nxt, env_nxt;
  logic                square_q;
  logic [SAMPLE_W-1:0] amp_q;
  logic [SAMPLE_W-1:0] sample_q;
  env_state_t          state_q;

  logic env_step;
  logic note_off;
  logic bypass;
  logic to_idle;

  // Returns {overflow, next accumulator}; keeps acc < CLK_HZ so the rate is exact on average.
  function automatic logic [ACC_W:0] acc_step(input logic [ACC_W-1:0] acc,
                                               input logic [ACC_W-1:0] inc);
    logic [ACC_W:0] t;
    t = {1'b0, acc} + {1'b0, inc};
    if (t >= ClkHz) begin
      return {1'b1, ACC_W'(t - ClkHz)};
    end
    return {1'b0, t[ACC_W-1:0]};
  endfunction

  assign tone_nxt = acc_step(tacc_q, ACC_W'({freq_hold_q, 1'b0}));
  assign env_nxt  = acc_step(eacc_q, ACC_W'(rate_hold_q));
  assign env_step = env_nxt[ACC_W];
  assign note_off = (freq_q == '0);
  assign bypass   = (rate_hold_q == '0);

  // Release finished, or a bypassed note let go: drop straight to silence.
  assign to_idle = (state_q != IDLE) && note_off &&
                   (bypass || ((state_q == RELEASE) && (amp_q == '0)));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      freq_q      <= '0;
      rate_q      <= '0;
      freq_hold_q <= '0;
      rate_hold_q <= '0;
      tacc_q      <= '0;
      eacc_q      <= '0;
      square_q    <= 1'b0;
      amp_q       <= '0;
      sample_q    <= '0;
      state_q     <= IDLE;
    end else begin
      freq_q   <= voice.sample_rate;
      rate_q   <= voice.arm_Rate;
      sample_q <= square_q ? amp_q : '0;

      // Holds freeze while the key is up so the release tail keeps its pitch.
      if (!note_off) begin
        freq_hold_q <= freq_q;
        rate_hold_q <= rate_q;
      end

      if (state_q != IDLE) begin
        tacc_q <= tone_nxt[ACC_W-1:0];
        eacc_q <= env_nxt[ACC_W-1:0];
        if (tone_nxt[ACC_W]) begin
          square_q <= ~square_q;
        end
      end

      if (to_idle) begin
        state_q  <= IDLE;
        amp_q    <= '0;
        square_q <= 1'b0;
        tacc_q   <= '0;
        eacc_q   <= '0;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (!note_off) begin
              if (rate_q == '0) begin
                amp_q   <= AmpMax;
                state_q <= SUSTAIN;
              end else begin
                state_q <= ATTACK;
              end
            end
          end
          ATTACK: begin
            if (note_off) begin
              state_q <= RELEASE;
            end else if (bypass) begin
              amp_q   <= AmpMax;
              state_q <= SUSTAIN;
            end else if (amp_q == AmpMax) begin
              state_q <= DECAY;
            end else if (env_step) begin
              amp_q <= amp_q + 1'b1;
            end
          end
          DECAY: begin
            if (note_off) begin
              state_q <= RELEASE;
            end else if (bypass) begin
              amp_q   <= AmpMax;
              state_q <= SUSTAIN;
            end else if (amp_q <= SustainLvl) begin
              state_q <= SUSTAIN;
            end else if (env_step) begin
              amp_q <= amp_q - 1'b1;
            end
          end
          SUSTAIN: begin
            if (note_off) begin
              state_q <= RELEASE;
            end
          end
          RELEASE: begin
            if (!note_off) begin
              state_q <= ATTACK;
            end else if (env_step) begin
              amp_q <= amp_q - 1'b1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign voice.sample      = sample_q;
  assign voice.note_active = (state_q != IDLE);

  pwm_dac u_pwm_dac (
    .clk   (clk),
    .reset (reset),
    .level (sample_q),
    .pwm   (voice.audio_pwm)
  );

endmodule

// File: tb/tb_tone_voice.sv
// Self-checking bench for tone_voice at CLK_HZ = 100_000.
module tb_tone_voice;
  import piano_pkg::*;

  localparam int unsigned CLK_HZ = 100_000;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  tone_voice_if vif ();

  tone_voice #(
    .CLK_HZ      (CLK_HZ),
    .SUSTAIN_LVL (192)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .voice (vif)
  );

  logic [7:0] pwm_level = 8'd0;
  logic       pwm_out;

  pwm_dac u_pwm_ref (
    .clk   (clk),
    .reset (reset),
    .level (pwm_level),
    .pwm   (pwm_out)
  );

  int tests_run = 0;
  int tests_failed = 0;
  int exp_q[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    vif.sample_rate = 16'd0;
    vif.arm_Rate = 16'd0;
    repeat (3) tick();
    reset = 1'b1;
    tick();
  endtask

  // Min/max clocks between square toggles over n intervals; first partial interval is skipped.
  task automatic measure_half(input int n, output int mn, output int mx);
    int len = 0;
    int seen = 0;
    int budget = 0;
    logic prev;
    mn = 1 << 30;
    mx = 0;
    prev = dut.square_q;
    while (seen < n + 1 && budget < 200 * (n + 1)) begin
      tick();
      budget++;
      len++;
      if (dut.square_q != prev) begin
        if (seen > 0) begin
          if (len < mn) mn = len;
          if (len > mx) mx = len;
        end
        seen++;
        len = 0;
        prev = dut.square_q;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    vif.sample_rate = 16'd1046;
    vif.arm_Rate = 16'd300;
    repeat (4) tick();
    tests_run++;
    if (vif.sample !== 8'd0) begin
      tests_failed++;
      $display("FAIL reset_sample: got %0d want 0", vif.sample);
    end
    tests_run++;
    if (vif.audio_pwm !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_pwm: got %b want 0", vif.audio_pwm);
    end
    tests_run++;
    if (vif.note_active !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_active: got %b want 0", vif.note_active);
    end
    reset = 1'b1;
    tick();
    tests_run++;
    if (vif.note_active !== 1'b0) begin
      tests_failed++;
      $display("FAIL noteon_latency_k: got %b want 0", vif.note_active);
    end
    tick();
    tests_run++;
    if (vif.note_active !== 1'b1) begin
      tests_failed++;
      $display("FAIL noteon_latency_k1: got %b want 1", vif.note_active);
    end
  endtask

  task automatic test_pitch();
    int rises = 0;
    int e;
    int mn, mx;
    int lo;
    logic prev;
    do_reset();
    vif.sample_rate = 16'd1046;
    vif.arm_Rate = 16'd300;
    repeat (3) tick();
    exp_q.push_back(1046 * 20_000 / CLK_HZ);
    prev = dut.square_q;
    for (int i = 0; i < 20_000; i++) begin
      tick();
      if (dut.square_q && !prev) rises++;
      prev = dut.square_q;
    end
    e = exp_q.pop_front();
    tests_run++;
    if (rises < e - 1 || rises > e + 1) begin
      tests_failed++;
      $display("FAIL pitch_rises: got %0d want %0d+-1", rises, e);
    end
    lo = CLK_HZ / (2 * 1046);
    measure_half(40, mn, mx);
    tests_run++;
    if (mn < lo || mx > lo + 1) begin
      tests_failed++;
      $display("FAIL pitch_half: got %0d..%0d want %0d..%0d", mn, mx, lo, lo + 1);
    end
  endtask

  task automatic test_envelope();
    int cnt = 0;
    int e;
    bit mono_ok = 1'b1;
    bit hold_ok = 1'b1;
    logic [7:0] prev;
    do_reset();
    vif.arm_Rate = 16'd3000;
    vif.sample_rate = 16'd1046;
    exp_q.push_back(255 * CLK_HZ / 3000);
    exp_q.push_back(63 * CLK_HZ / 3000);
    prev = dut.amp_q;
    while (dut.amp_q != 8'd255 && cnt < 20_000) begin
      tick();
      cnt++;
      if (dut.amp_q < prev || dut.amp_q > prev + 8'd1) mono_ok = 1'b0;
      prev = dut.amp_q;
    end
    e = exp_q.pop_front();
    tests_run++;
    if (cnt < e - 255 || cnt > e + 255) begin
      tests_failed++;
      $display("FAIL attack_time: got %0d want %0d+-255", cnt, e);
    end
    tests_run++;
    if (!mono_ok) begin
      tests_failed++;
      $display("FAIL attack_monotonic: got 0 want 1");
    end
    cnt = 0;
    while (dut.amp_q != 8'd192 && cnt < 10_000) begin
      tick();
      cnt++;
    end
    e = exp_q.pop_front();
    tests_run++;
    if (cnt < e - 64 || cnt > e + 64) begin
      tests_failed++;
      $display("FAIL decay_time: got %0d want %0d+-64", cnt, e);
    end
    tick();
    for (int i = 0; i < 2000; i++) begin
      tick();
      if (dut.amp_q != 8'd192 || dut.state_q != SUSTAIN) hold_ok = 1'b0;
    end
    tests_run++;
    if (!hold_ok) begin
      tests_failed++;
      $display("FAIL sustain_hold: got amp %0d state %s want 192 SUSTAIN",
               dut.amp_q, dut.state_q.name());
    end
  endtask

  task automatic test_release_retrigger();
    int mn, mx;
    int cnt = 0;
    int lo;
    bit down_ok = 1'b1;
    bit up_ok = 1'b1;
    logic [7:0] prev;
    vif.sample_rate = 16'd0;
    tick();
    tests_run++;
    if (dut.state_q !== SUSTAIN) begin
      tests_failed++;
      $display("FAIL noteoff_latency_k: got %s want SUSTAIN", dut.state_q.name());
    end
    tick();
    tests_run++;
    if (dut.state_q !== RELEASE) begin
      tests_failed++;
      $display("FAIL noteoff_latency_k1: got %s want RELEASE", dut.state_q.name());
    end
    lo = CLK_HZ / (2 * 1046);
    measure_half(20, mn, mx);
    tests_run++;
    if (mn < lo || mx > lo + 1) begin
      tests_failed++;
      $display("FAIL release_pitch: got %0d..%0d want %0d..%0d", mn, mx, lo, lo + 1);
    end
    prev = dut.amp_q;
    while (dut.amp_q != 8'd100 && cnt < 10_000) begin
      tick();
      cnt++;
      if (dut.amp_q > prev || dut.amp_q + 8'd1 < prev) down_ok = 1'b0;
      prev = dut.amp_q;
    end
    tests_run++;
    if (dut.amp_q !== 8'd100 || !down_ok) begin
      tests_failed++;
      $display("FAIL release_decrement: got amp %0d ok %0d want 100 ok 1", dut.amp_q, down_ok);
    end
    vif.sample_rate = 16'd1046;
    tick();
    tick();
    tests_run++;
    if (dut.state_q !== ATTACK) begin
      tests_failed++;
      $display("FAIL retrigger_state: got %s want ATTACK", dut.state_q.name());
    end
    tests_run++;
    if (dut.amp_q < 8'd99 || dut.amp_q > 8'd100) begin
      tests_failed++;
      $display("FAIL retrigger_amp: got %0d want 99..100", dut.amp_q);
    end
    cnt = 0;
    while (dut.amp_q != 8'd110 && cnt < 2000) begin
      tick();
      cnt++;
      if (dut.amp_q < 8'd99) up_ok = 1'b0;
    end
    tests_run++;
    if (dut.amp_q !== 8'd110 || !up_ok) begin
      tests_failed++;
      $display("FAIL retrigger_climb: got amp %0d ok %0d want 110 ok 1", dut.amp_q, up_ok);
    end
  endtask

  task automatic test_bypass_legato();
    int mn, mx;
    int lo;
    do_reset();
    vif.arm_Rate = 16'd0;
    vif.sample_rate = 16'd1318;
    tick();
    tick();
    tests_run++;
    if (dut.amp_q !== 8'd255 || dut.state_q !== SUSTAIN) begin
      tests_failed++;
      $display("FAIL bypass_on: got amp %0d state %s want 255 SUSTAIN",
               dut.amp_q, dut.state_q.name());
    end
    exp_q.push_back(CLK_HZ / (2 * 1318));
    measure_half(20, mn, mx);
    lo = exp_q.pop_front();
    tests_run++;
    if (mn < lo || mx > lo + 1) begin
      tests_failed++;
      $display("FAIL bypass_pitch: got %0d..%0d want %0d..%0d", mn, mx, lo, lo + 1);
    end
    vif.sample_rate = 16'd1396;
    tick();
    tick();
    tests_run++;
    if (dut.amp_q !== 8'd255 || dut.state_q !== SUSTAIN) begin
      tests_failed++;
      $display("FAIL legato_hold: got amp %0d state %s want 255 SUSTAIN",
               dut.amp_q, dut.state_q.name());
    end
    exp_q.push_back(CLK_HZ / (2 * 1396));
    measure_half(20, mn, mx);
    lo = exp_q.pop_front();
    tests_run++;
    if (mn < lo || mx > lo + 1) begin
      tests_failed++;
      $display("FAIL legato_pitch: got %0d..%0d want %0d..%0d", mn, mx, lo, lo + 1);
    end
    vif.sample_rate = 16'd0;
    tick();
    tick();
    tests_run++;
    if (vif.note_active !== 1'b0 || dut.amp_q !== 8'd0) begin
      tests_failed++;
      $display("FAIL bypass_off: got active %b amp %0d want 0 0", vif.note_active, dut.amp_q);
    end
    tick();
    tests_run++;
    if (vif.sample !== 8'd0) begin
      tests_failed++;
      $display("FAIL bypass_off_sample: got %0d want 0", vif.sample);
    end
  endtask

  task automatic test_reset_mid_note();
    int cnt = 0;
    vif.arm_Rate = 16'd0;
    vif.sample_rate = 16'd1318;
    repeat (3) tick();
    while (vif.sample == 8'd0 && cnt < 200) begin
      tick();
      cnt++;
    end
    tests_run++;
    if (vif.sample !== 8'd255) begin
      tests_failed++;
      $display("FAIL midnote_sample: got %0d want 255", vif.sample);
    end
    #2;
    reset = 1'b0;
    #1;
    tests_run++;
    if (vif.sample !== 8'd0 || vif.note_active !== 1'b0 || vif.audio_pwm !== 1'b0) begin
      tests_failed++;
      $display("FAIL midnote_reset: got sample %0d active %b pwm %b want 0 0 0",
               vif.sample, vif.note_active, vif.audio_pwm);
    end
    tests_run++;
    if (dut.state_q !== IDLE || dut.amp_q !== 8'd0) begin
      tests_failed++;
      $display("FAIL midnote_state: got %s amp %0d want IDLE 0", dut.state_q.name(), dut.amp_q);
    end
    vif.sample_rate = 16'd0;
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_pwm();
    logic [7:0] levels[5] = '{8'd128, 8'd255, 8'd0, 8'd1, 8'd37};
    int highs;
    int e;
    for (int i = 0; i < 5; i++) begin
      pwm_level = levels[i];
      exp_q.push_back(int'(levels[i]));
      tick();
      highs = 0;
      for (int c = 0; c < 256; c++) begin
        tick();
        if (pwm_out) highs++;
      end
      e = exp_q.pop_front();
      tests_run++;
      if (highs != e) begin
        tests_failed++;
        $display("FAIL pwm_duty_%0d: got %0d high want %0d", i, highs, e);
      end
    end
  endtask

  initial begin
    vif.sample_rate = 16'd0;
    vif.arm_Rate = 16'd0;
    test_reset();
    test_pitch();
    test_envelope();
    test_release_retrigger();
    test_bypass_legato();
    test_reset_mid_note();
    test_pwm();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
